// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash-to-audio-player fetch controller.
package flash_reader_pkg;

    localparam int unsigned FLASH_ADDR_W = 23;
    localparam int unsigned FLASH_DATA_W = 32;
    localparam logic [FLASH_ADDR_W-1:0] AUDIO_LAST_ADDR = 23'h7FFFF;
    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        WAIT_VALID,
        START_HI,
        WAIT_FIN_HI,
        WAIT_FIN_LO,
        ADVANCE
    } fr_state_t;

endpackage

// File: rtl/flash_reader_ctrl_if.sv
// Flash Avalon-MM read port plus audio_player start/finished handshake.
interface flash_reader_ctrl_if #(
    parameter int unsigned ADDR_W = flash_reader_pkg::FLASH_ADDR_W
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic              flash_mem_waitrequest;
    logic [31:0]       flash_mem_readdata;
    logic              flash_mem_readdatavalid;
    logic              player_start;
    logic [31:0]       player_data;
    logic              player_finished;
    logic              word_done;

    modport master (
        output flash_mem_read, flash_mem_address, flash_mem_byteenable,
        input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        output player_start, player_data, word_done,
        input  player_finished
    );

    modport slave (
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
        output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
        input  player_start, player_data, word_done,
        output player_finished
    );

endinterface

// File: rtl/flash_addr_counter.sv
// Up/down word-address counter with explicit wrap at 0 / LAST_ADDR and restart.
module flash_addr_counter #(
    parameter int unsigned       ADDR_W    = flash_reader_pkg::FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(flash_reader_pkg::AUDIO_LAST_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              forward,
    input  logic              restart,
    output logic [ADDR_W-1:0] address
);

    // Restart outranks a normal step; wrap is compared, never left to overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            address <= '0;
        end else if (restart) begin
            address <= forward ? '0 : LAST_ADDR;
        end else if (en) begin
            if (forward) begin
                address <= (address == LAST_ADDR) ? '0 : address + ADDR_W'(1);
            end else begin
                address <= (address == '0) ? LAST_ADDR : address - ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/flash_reader_ctrl.sv
// Walks the audio file in flash word by word and hands each word to audio_player.
module flash_reader_ctrl
    import flash_reader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(AUDIO_LAST_ADDR)
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic play,
    input  logic forward,
    input  logic restart,
    flash_reader_ctrl_if.master bus
);

    fr_state_t   state, state_d;
    logic        read_q, read_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        latch;
    logic [31:0] data_q;
    logic        restart_pend;
    logic        restart_any;
    logic        restart_apply;
    logic        cnt_en;

    // A pending restart is consumed either while parked or at the word boundary.
    assign restart_any   = restart_pend | restart;
    assign restart_apply = restart_any & ((state == IDLE) | (state == ADVANCE));
    assign cnt_en        = (state == ADVANCE);

    flash_addr_counter #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr (
        .clk     (clk_50MHz),
        .reset   (reset),
        .en      (cnt_en),
        .forward (forward),
        .restart (restart_apply),
        .address (bus.flash_mem_address)
    );

    always_comb begin
        state_d = state;
        latch   = 1'b0;
        start_d = 1'b0;
        case (state)
            IDLE: begin
                if (play) state_d = READ_REQ;
            end
            READ_REQ: begin
                if (!bus.flash_mem_waitrequest) begin
                    if (bus.flash_mem_readdatavalid) begin
                        latch   = 1'b1;
                        state_d = START_HI;
                    end else begin
                        state_d = WAIT_VALID;
                    end
                end
            end
            WAIT_VALID: begin
                if (bus.flash_mem_readdatavalid) begin
                    latch   = 1'b1;
                    state_d = START_HI;
                end
            end
            START_HI: begin
                start_d = 1'b1;
                state_d = WAIT_FIN_HI;
            end
            WAIT_FIN_HI: begin
                if (bus.player_finished) state_d = WAIT_FIN_LO;
                else                     start_d = 1'b1;
            end
            WAIT_FIN_LO: begin
                if (!bus.player_finished) state_d = ADVANCE;
            end
            ADVANCE: begin
                state_d = play ? READ_REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Read and word_done follow the state being entered so they align with it.
        read_d = (state_d == READ_REQ);
        done_d = (state_d == ADVANCE);
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state        <= IDLE;
            read_q       <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            data_q       <= '0;
            restart_pend <= 1'b0;
        end else begin
            state        <= state_d;
            read_q       <= read_d;
            start_q      <= start_d;
            done_q       <= done_d;
            restart_pend <= restart_any & ~restart_apply;
            if (latch) data_q <= bus.flash_mem_readdata;
        end
    end

    assign bus.flash_mem_read       = read_q;
    assign bus.flash_mem_byteenable = BYTEENABLE_ALL;
    assign bus.player_start         = start_q;
    assign bus.player_data          = data_q;
    assign bus.word_done            = done_q;

endmodule

// File: tb/tb_flash_reader_ctrl.sv
// Directed scoreboard bench for flash_reader_ctrl with a simple flash/player model.
module tb_flash_reader_ctrl;
    import flash_reader_pkg::*;

    logic clk = 1'b0;
    logic reset, play, forward, restart;

    flash_reader_ctrl_if bus ();

    flash_reader_ctrl dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .play      (play),
        .forward   (forward),
        .restart   (restart),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete word: read request, optional stall, data, handshake, advance.
    task automatic serve_word(input logic [22:0] addr, input logic [31:0] data,
                              input int stall, input bit drop_play, input bit do_restart);
        int n;
        logic [22:0] ea;
        logic [31:0] ed;
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(data);
        n = 0;
        while (!bus.flash_mem_read && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("read_seen", 64'(bus.flash_mem_read), 64'd1);
        ea = exp_addr_q.pop_front();
        check("read_addr", 64'(bus.flash_mem_address), 64'(ea));
        bus.flash_mem_waitrequest = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_read", 64'(bus.flash_mem_read), 64'd1);
            check("stall_addr", 64'(bus.flash_mem_address), 64'(ea));
        end
        bus.flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        check("wait_valid_read", 64'(bus.flash_mem_read), 64'd0);
        bus.flash_mem_readdatavalid = 1'b1;
        bus.flash_mem_readdata      = data;
        @(negedge clk);
        bus.flash_mem_readdatavalid = 1'b0;
        bus.flash_mem_readdata      = 32'hDEAD_BEEF;
        n = 0;
        while (!bus.player_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_latency", 64'(n), 64'd1);
        ed = exp_data_q.pop_front();
        check("player_data", 64'(bus.player_data), 64'(ed));
        if (drop_play)  play    = 1'b0;
        if (do_restart) restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("start_held", 64'(bus.player_start), 64'd1);
        bus.player_finished = 1'b1;
        @(negedge clk);
        check("start_drop", 64'(bus.player_start), 64'd0);
        check("data_stable", 64'(bus.player_data), 64'(ed));
        bus.player_finished = 1'b0;
        n = 0;
        while (!bus.word_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("word_done", 64'(bus.word_done), 64'd1);
        @(negedge clk);
        check("word_done_pulse", 64'(bus.word_done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; forward = 1'b1; restart = 1'b0;
        bus.flash_mem_waitrequest   = 1'b0;
        bus.flash_mem_readdata      = 32'hDEAD_BEEF;
        bus.flash_mem_readdatavalid = 1'b0;
        bus.player_finished         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read",  64'(bus.flash_mem_read), 64'd0);
        check("rst_start", 64'(bus.player_start), 64'd0);
        check("rst_data",  64'(bus.player_data), 64'd0);
        check("rst_done",  64'(bus.word_done), 64'd0);
        check("rst_addr",  64'(bus.flash_mem_address), 64'd0);
        check("byteen",    64'(bus.flash_mem_byteenable), 64'hF);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_read", 64'(bus.flash_mem_read), 64'd0);

        play = 1'b1;
        serve_word(23'd0, 32'hFFFF_1111, 0, 1'b0, 1'b0);
        forward = 1'b0;
        serve_word(23'd1, 32'h1234_5678, 0, 1'b0, 1'b0);
        serve_word(23'd0, 32'hA5A5_0F0F, 0, 1'b0, 1'b0);
        forward = 1'b1;
        serve_word(23'h7FFFF, 32'h0BAD_F00D, 0, 1'b0, 1'b0);
        serve_word(23'd0, 32'h3333_CCCC, 5, 1'b0, 1'b0);
        serve_word(23'd1, 32'h5555_AAAA, 0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("paused_no_read", 64'(bus.flash_mem_read), 64'd0);
        end
        check("paused_addr", 64'(bus.flash_mem_address), 64'd2);
        play = 1'b1;
        for (int a = 2; a < 256; a++) begin
            serve_word(23'(a), $urandom, 0, 1'b0, 1'b0);
        end
        serve_word(23'h100, 32'hC0DE_0100, 0, 1'b0, 1'b1);

        // Abort in WAIT_VALID: reset must clear everything and drop the pending read.
        begin
            int n;
            n = 0;
            while (!bus.flash_mem_read && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("restart_addr", 64'(bus.flash_mem_address), 64'd0);
            @(negedge clk);
            play  = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            check("abort_read",  64'(bus.flash_mem_read), 64'd0);
            check("abort_start", 64'(bus.player_start), 64'd0);
            check("abort_data",  64'(bus.player_data), 64'd0);
            check("abort_done",  64'(bus.word_done), 64'd0);
            reset = 1'b0;
            bus.flash_mem_readdatavalid = 1'b1;
            bus.flash_mem_readdata      = 32'h7777_8888;
            @(negedge clk);
            bus.flash_mem_readdatavalid = 1'b0;
            repeat (3) @(negedge clk);
            check("stale_valid_data",  64'(bus.player_data), 64'd0);
            check("stale_valid_start", 64'(bus.player_start), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
